cdc_2phase_dst_rx: RTL and testbench

- Receiving end of the 2-phase (toggle req/ack) CDC protocol.
- Lives entirely in the destination clock domain. Synchronizes the incoming toggle request, captures the bundled data into a registered valid/ready stream output, and returns a toggle acknowledge.
- Pairs with any single-clock 2-phase transmitter on the source side, so the two halves can be placed and constrained separately.

---
 rtl/cdc_2phase_pkg.sv | 6 +
 rtl/cdc_2phase_sync.sv | 14 +
 rtl/cdc_2phase_dst_rx.sv | 61 ++++++
 tb/tb_cdc_2phase_dst_rx.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cdc_2phase_pkg.sv
// cdc_2phase_pkg: shared defaults and counter type for the 2-phase CDC blocks
package cdc_2phase_pkg;
  localparam int DefaultSyncStages = 2;
  localparam int DefaultCntWidth = 16;
  typedef logic [DefaultCntWidth-1:0] cnt_t;
endpackage

// File: rtl/cdc_2phase_sync.sv
// cdc_2phase_sync: N-stage bit synchronizer with synchronous active-low reset to 0
module cdc_2phase_sync #(
  parameter int N = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);
  logic [N-1:0] sync_q, sync_d;
  always_comb sync_d = {sync_q[N-2:0], d_i};
  always_ff @(posedge clk_i) sync_q <= !rst_ni ? '0 : sync_d;
  assign q_o = sync_q[N-1];
endmodule

// File: rtl/cdc_2phase_dst_rx.sv
// cdc_2phase_dst_rx: 2-phase CDC receiver to valid/ready stream; CDC_2PHASE_DST_RX_STATS_EN adds xfer/drop counters
module cdc_2phase_dst_rx
  import cdc_2phase_pkg::*;
#(
  parameter type T = logic,
  parameter int SyncStages = DefaultSyncStages,
  parameter int CntWidth = DefaultCntWidth
) (
  input  logic dst_clk_i,
  input  logic dst_rst_ni,
  input  logic dst_clr_i,
  input  logic async_req_i,
  input  T     async_data_i,
  output logic async_ack_o,
  output T     dst_data_o,
  output logic dst_valid_o,
  input  logic dst_ready_i
`ifdef CDC_2PHASE_DST_RX_STATS_EN
  ,
  output logic [CntWidth-1:0] xfer_cnt_o,
  output logic [CntWidth-1:0] drop_cnt_o
`endif
);
  logic req_s, pending, capture;
  logic ack_q, ack_d, valid_q, valid_d;
  T data_q, data_d;
  cdc_2phase_sync #(.N(SyncStages)) u_req_sync (
    .clk_i (dst_clk_i),
    .rst_ni(dst_rst_ni),
    .d_i   (async_req_i),
    .q_o   (req_s)
  );
  always_comb begin
    pending = req_s ^ ack_q;
    capture = pending && (!valid_q || dst_ready_i) && !dst_clr_i;
    ack_d   = dst_clr_i ? req_s : (capture ? ~ack_q : ack_q);
    valid_d = dst_clr_i ? 1'b0 : capture ? 1'b1 : (valid_q && dst_ready_i) ? 1'b0 : valid_q;
    data_d  = capture ? async_data_i : data_q;
  end
  always_ff @(posedge dst_clk_i) begin
    ack_q   <= !dst_rst_ni ? 1'b0 : ack_d;
    valid_q <= !dst_rst_ni ? 1'b0 : valid_d;
    data_q  <= !dst_rst_ni ? '0 : data_d;
  end
  assign async_ack_o = ack_q;
  assign dst_valid_o = valid_q;
  assign dst_data_o  = data_q;
`ifdef CDC_2PHASE_DST_RX_STATS_EN
  logic [CntWidth-1:0] xfer_q, xfer_d, drop_q, drop_d;
  always_comb begin
    xfer_d = xfer_q + CntWidth'(valid_q && dst_ready_i);
    drop_d = drop_q + CntWidth'(dst_clr_i && valid_q) + CntWidth'(dst_clr_i && pending);
  end
  always_ff @(posedge dst_clk_i) begin
    xfer_q <= !dst_rst_ni ? '0 : xfer_d;
    drop_q <= !dst_rst_ni ? '0 : drop_d;
  end
  assign xfer_cnt_o = xfer_q;
  assign drop_cnt_o = drop_q;
`endif
endmodule

// File: tb/tb_cdc_2phase_dst_rx.sv
// tb_cdc_2phase_dst_rx: randomized self-checking bench for cdc_2phase_dst_rx
module tb_cdc_2phase_dst_rx;
  logic clk = 1'b0;
  logic rst_n, clr, req, ack, valid, ready;
  logic [31:0] din, dout;
`ifdef CDC_2PHASE_DST_RX_STATS_EN
  logic [3:0] xfer_cnt, drop_cnt;
`endif
  int n_checks = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  cdc_2phase_dst_rx #(
    .T(logic [31:0]),
    .SyncStages(2),
    .CntWidth(4)
  ) dut (
    .dst_clk_i   (clk),
    .dst_rst_ni  (rst_n),
    .dst_clr_i   (clr),
    .async_req_i (req),
    .async_data_i(din),
    .async_ack_o (ack),
    .dst_data_o  (dout),
    .dst_valid_o (valid),
    .dst_ready_i (ready)
`ifdef CDC_2PHASE_DST_RX_STATS_EN
    ,
    .xfer_cnt_o  (xfer_cnt),
    .drop_cnt_o  (drop_cnt)
`endif
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [31:0] d);
    din = d;
    req = ~req;
  endtask
  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; ready = 1'b0; req = 1'b1; din = 32'h1234_5678;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (ack !== 1'b0 || valid !== 1'b0 || dout !== 32'h0) begin
        n_fail++;
        $display("FAIL reset_hold cyc%0d: ack=%b valid=%b data=%h, want 0/0/0", i, ack, valid, dout);
      end
    end
    rst_n = 1'b1;
    ready = 1'b1;
    for (int e = 1; e <= 3; e++) begin
      tick();
      n_checks++;
      if (e < 3 && (valid !== 1'b0 || ack !== 1'b0)) begin
        n_fail++;
        $display("FAIL reset_release_early edge%0d: valid=%b ack=%b, want 0/0", e, valid, ack);
      end else if (e == 3 && (valid !== 1'b1 || ack !== 1'b1 || dout !== 32'h1234_5678)) begin
        n_fail++;
        $display("FAIL reset_release_edge3: valid=%b ack=%b data=%h, want 1/1/12345678", valid, ack, dout);
      end
    end
    tick();
  endtask
  task automatic test_single();
    logic exp_ack;
    ready = 1'b1;
    exp_ack = ~ack;
    send(32'hDEAD_BEEF);
    for (int e = 1; e <= 4; e++) begin
      tick();
      n_checks++;
      if (e < 3 && (valid !== 1'b0 || ack !== ~exp_ack)) begin
        n_fail++;
        $display("FAIL single_latency edge%0d: valid=%b ack=%b, want 0/%b", e, valid, ack, ~exp_ack);
      end else if (e == 3 && (valid !== 1'b1 || dout !== 32'hDEAD_BEEF || ack !== exp_ack)) begin
        n_fail++;
        $display("FAIL single_capture: valid=%b data=%h ack=%b, want 1/deadbeef/%b", valid, dout, ack, exp_ack);
      end else if (e == 4 && valid !== 1'b0) begin
        n_fail++;
        $display("FAIL single_drain: valid=%b, want 0", valid);
      end
    end
  endtask
  task automatic test_backpressure();
    logic ph;
    ready = 1'b0;
    send(32'h1);
    repeat (3) tick();
    ph = ack;
    n_checks++;
    if (valid !== 1'b1 || dout !== 32'h1 || ph !== req) begin
      n_fail++;
      $display("FAIL bp_first: valid=%b data=%h ack=%b, want 1/1/%b", valid, dout, ph, req);
    end
    send(32'h2);
    repeat (5) tick();
    n_checks++;
    if (valid !== 1'b1 || dout !== 32'h1 || ack !== ph) begin
      n_fail++;
      $display("FAIL bp_hold: valid=%b data=%h ack=%b, want 1/1/%b", valid, dout, ack, ph);
    end
    ready = 1'b1;
    tick();
    n_checks++;
    if (valid !== 1'b1 || dout !== 32'h2 || ack !== ~ph) begin
      n_fail++;
      $display("FAIL bp_reload: valid=%b data=%h ack=%b, want 1/2/%b", valid, dout, ack, ~ph);
    end
    tick();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL bp_drain: valid=%b, want 0", valid);
    end
  endtask
  task automatic test_back_to_back();
    logic [31:0] exp_q[$];
    logic [31:0] w, last_d;
    int sent = 0, got = 0, cyc = 0;
    logic stall = 1'b0;
    while (got < 100 && cyc < 20000) begin
      if (stall) begin
        n_checks++;
        if (valid !== 1'b1 || dout !== last_d) begin
          n_fail++;
          $display("FAIL b2b_stable: valid=%b data=%h, want 1/%h", valid, dout, last_d);
        end
      end
      ready = ($urandom_range(0, 2) != 0);
      if (valid && ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL b2b_extra: data=%h, want nothing", dout);
        end else begin
          w = exp_q.pop_front();
          if (dout !== w) begin
            n_fail++;
            $display("FAIL b2b_data #%0d: data=%h, want %h", got, dout, w);
          end
        end
        got++;
      end
      stall = valid && !ready;
      last_d = dout;
      if (ack == req && sent < 100) begin
        w = $urandom();
        exp_q.push_back(w);
        send(w);
        sent++;
      end
      tick();
      cyc++;
    end
    ready = 1'b1;
    n_checks++;
    if (got != 100 || exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL b2b_count: received=%0d left=%0d, want 100/0", got, exp_q.size());
    end
    repeat (2) tick();
  endtask
  task automatic test_clear();
    ready = 1'b0;
    send(32'h1111_1111);
    repeat (3) tick();
    send(32'h2222_2222);
    repeat (3) tick();
    n_checks++;
    if (valid !== 1'b1 || ack === req) begin
      n_fail++;
      $display("FAIL clr_setup: valid=%b ack=%b, want 1/%b", valid, ack, ~req);
    end
    clr = 1'b1;
    tick();
    clr = 1'b0;
    n_checks++;
    if (valid !== 1'b0 || ack !== req) begin
      n_fail++;
      $display("FAIL clr_flush: valid=%b ack=%b, want 0/%b", valid, ack, req);
    end
`ifdef CDC_2PHASE_DST_RX_STATS_EN
    n_checks++;
    if (drop_cnt !== 4'd2) begin
      n_fail++;
      $display("FAIL clr_drop_cnt: got %0d, want 2", drop_cnt);
    end
`endif
    repeat (3) tick();
    n_checks++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL clr_no_ghost: valid=%b, want 0", valid);
    end
    ready = 1'b1;
    send(32'hA5A5_A5A5);
    repeat (3) tick();
    n_checks++;
    if (valid !== 1'b1 || dout !== 32'hA5A5_A5A5 || ack !== req) begin
      n_fail++;
      $display("FAIL clr_next: valid=%b data=%h ack=%b, want 1/a5a5a5a5/%b", valid, dout, ack, req);
    end
    tick();
  endtask
`ifdef CDC_2PHASE_DST_RX_STATS_EN
  task automatic test_stats_wrap();
    int t;
    rst_n = 1'b0; req = 1'b0; ready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 17; i++) begin
      send($urandom());
      t = 0;
      while (ack != req && t < 50) begin
        tick();
        t++;
      end
      tick();
    end
    tick();
    n_checks++;
    if (xfer_cnt !== 4'd1 || drop_cnt !== 4'd0) begin
      n_fail++;
      $display("FAIL stats_wrap: xfer=%0d drop=%0d, want 1/0", xfer_cnt, drop_cnt);
    end
  endtask
`endif
  initial begin
    test_reset();
    test_single();
    test_backpressure();
    test_back_to_back();
    test_clear();
`ifdef CDC_2PHASE_DST_RX_STATS_EN
    test_stats_wrap();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
